// File: rtl/bomberman_pkg.sv
// Shared types and screen constants for the bomb placement / fuse / flame blocks.
package bomberman_pkg;

  localparam int unsigned POS_W        = 10;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned SCREEN_X_MAX = 639;
  localparam int unsigned SCREEN_Y_MAX = 479;

  typedef logic [CNT_W-1:0] frame_cnt_t;
  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BLAST = 2'd2,
    FLAME = 2'd3
  } fuse_state_t;

  // One axis of the flame cross: low and high pixel edges.
  typedef struct packed {
    pos_t lo;
    pos_t hi;
  } span_t;

endpackage

// File: rtl/flame_clamp.sv
// Combinational flame extent for one axis: centre +/- range, clamped to [0, limit].
module flame_clamp
  import bomberman_pkg::*;
(
  input  pos_t  centre,
  input  pos_t  range,
  input  pos_t  limit,
  output span_t span_c
);

  logic [POS_W:0] sum;
  logic [POS_W:0] diff;
  logic [POS_W:0] limit_w;

  always_comb begin
    limit_w = {1'b0, limit};
    sum     = {1'b0, centre} + {1'b0, range};
    diff    = {1'b0, centre} - {1'b0, range};
    // A parked (off-screen) centre saturates both edges to the limit.
    if (centre < range)       span_c.lo = '0;
    else if (diff > limit_w)  span_c.lo = limit;
    else                      span_c.lo = diff[POS_W-1:0];
    span_c.hi = (sum > limit_w) ? limit : sum[POS_W-1:0];
  end

endmodule

// File: rtl/bomb_fuse.sv
// Bomb fuse timer: arm on placement, count the fuse, request retirement, then drive the flame cross.
// Optional CHAIN_TRIGGER_EN adds chain_hit, which detonates an armed bomb early.
module bomb_fuse
  import bomberman_pkg::*;
#(
  parameter int unsigned FUSE_FRAMES   = 120,
  parameter int unsigned FLAME_FRAMES  = 30,
  parameter int unsigned FLAME_RANGE   = 32,
  parameter int unsigned X_MAX         = SCREEN_X_MAX,
  parameter int unsigned Y_MAX         = SCREEN_Y_MAX,
  parameter int unsigned BLAST_TIMEOUT = 4
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic             bomb_check,
  input  logic [POS_W-1:0] bombX,
  input  logic [POS_W-1:0] bombY,
`ifdef CHAIN_TRIGGER_EN
  input  logic             chain_hit,
`endif
  output logic             explode,
  output logic             fuse_warn,
  output logic             flame_active,
  output logic [POS_W-1:0] flameXL,
  output logic [POS_W-1:0] flameXR,
  output logic [POS_W-1:0] flameYT,
  output logic [POS_W-1:0] flameYB
);

  localparam frame_cnt_t FUSE_LOAD  = frame_cnt_t'(FUSE_FRAMES - 1);
  localparam frame_cnt_t FLAME_LOAD = frame_cnt_t'(FLAME_FRAMES - 1);
  localparam frame_cnt_t BLAST_LOAD = frame_cnt_t'(BLAST_TIMEOUT - 1);
  localparam frame_cnt_t WARN_LIMIT = frame_cnt_t'(FUSE_FRAMES / 4);
  localparam frame_cnt_t CNT_ONE    = frame_cnt_t'(1);

  fuse_state_t state_q, state_d;
  frame_cnt_t  cnt_q, cnt_d;
  pos_t        pos_x_q, pos_x_d;
  pos_t        pos_y_q, pos_y_d;
  logic        warn_d;
  logic        chain_go_c;
  span_t       x_span_c, y_span_c;

`ifdef CHAIN_TRIGGER_EN
  assign chain_go_c = chain_hit;
`else
  assign chain_go_c = 1'b0;
`endif

  flame_clamp u_clamp_x (
    .centre (pos_x_q),
    .range  (pos_t'(FLAME_RANGE)),
    .limit  (pos_t'(X_MAX)),
    .span_c (x_span_c)
  );

  flame_clamp u_clamp_y (
    .centre (pos_y_q),
    .range  (pos_t'(FLAME_RANGE)),
    .limit  (pos_t'(Y_MAX)),
    .span_c (y_span_c)
  );

  // Next-state, counter and latched-position logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    unique case (state_q)
      IDLE: if (bomb_check) begin
        pos_x_d = bombX;
        pos_y_d = bombY;
        cnt_d   = FUSE_LOAD;
        state_d = ARMED;
      end
      ARMED: begin
        if (!bomb_check) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0 || chain_go_c) begin
          cnt_d   = BLAST_LOAD;
          state_d = BLAST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      BLAST: begin
        if (!bomb_check || cnt_q == '0) begin
          cnt_d   = FLAME_LOAD;
          state_d = FLAME;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      FLAME: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = IDLE;
    endcase
    warn_d = (state_d == ARMED) && (cnt_d < WARN_LIMIT) && cnt_d[2];
  end

  // State register and registered outputs; flame edges captured on FLAME entry only.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      explode      <= 1'b0;
      fuse_warn    <= 1'b0;
      flame_active <= 1'b0;
      flameXL      <= '0;
      flameXR      <= '0;
      flameYT      <= '0;
      flameYB      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      explode      <= (state_q == BLAST);
      fuse_warn    <= warn_d;
      flame_active <= (state_d == FLAME);
      if (state_q == BLAST && state_d == FLAME) begin
        flameXL <= x_span_c.lo;
        flameXR <= x_span_c.hi;
        flameYT <= y_span_c.lo;
        flameYB <= y_span_c.hi;
      end
    end
  end

endmodule

// File: tb/tb_bomb_fuse.sv
// Scoreboard bench for bomb_fuse: stimulus queues expected output events, a monitor pops and compares.
module tb_bomb_fuse;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b0;
  logic       bomb_check = 1'b0;
  logic [9:0] bombX = '0;
  logic [9:0] bombY = '0;
`ifdef CHAIN_TRIGGER_EN
  logic       chain_hit = 1'b0;
`endif
  logic       explode, fuse_warn, flame_active;
  logic [9:0] flameXL, flameXR, flameYT, flameYB;

  bomb_fuse dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .bomb_check   (bomb_check),
    .bombX        (bombX),
    .bombY        (bombY),
`ifdef CHAIN_TRIGGER_EN
    .chain_hit    (chain_hit),
`endif
    .explode      (explode),
    .fuse_warn    (fuse_warn),
    .flame_active (flame_active),
    .flameXL      (flameXL),
    .flameXR      (flameXR),
    .flameYT      (flameYT),
    .flameYB      (flameYB)
  );

  always #5 frame_clk = ~frame_clk;

  typedef enum int {EV_XRISE, EV_XFALL, EV_FRISE, EV_FFALL} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
    int       xl, xr, yt, yb;
  } ev_t;

  ev_t sb[$];
  int  checks   = 0;
  int  fails    = 0;
  int  cyc      = 0;
  int  arm_cyc  = 0;
  int  ev_count = 0;

  always @(posedge frame_clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_t k, input int v, input int xl, input int xr,
                      input int yt, input int yb);
    ev_t e;
    e.kind = k; e.val = v; e.xl = xl; e.xr = xr; e.yt = yt; e.yb = yb;
    sb.push_back(e);
  endtask

  task automatic report(input ev_kind_t k, input int v);
    ev_t e;
    ev_count++;
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d value %0d, expected no event", int'(k), v);
      return;
    end
    e = sb.pop_front();
    check("event_kind", int'(k), int'(e.kind));
    if (k == EV_FRISE) begin
      check("flameXL", int'(flameXL), e.xl);
      check("flameXR", int'(flameXR), e.xr);
      check("flameYT", int'(flameYT), e.yt);
      check("flameYB", int'(flameYB), e.yb);
    end else if (k == EV_XRISE) begin
      check("explode_latency", v, e.val);
    end else if (k == EV_XFALL) begin
      check("explode_length", v, e.val);
    end else begin
      check("flame_length", v, e.val);
    end
  endtask

  // Monitor: turns output transitions into events for the scoreboard.
  logic x_prev = 1'b0, f_prev = 1'b0;
  int   x_len = 0, f_len = 0;
  always @(negedge frame_clk) begin
    if (!Reset) begin
      x_prev = 1'b0; f_prev = 1'b0; x_len = 0; f_len = 0;
    end else begin
      if (explode) begin
        if (!x_prev) begin x_len = 1; report(EV_XRISE, cyc - arm_cyc); end
        else x_len++;
      end else if (x_prev) report(EV_XFALL, x_len);
      if (flame_active) begin
        if (!f_prev) begin f_len = 1; report(EV_FRISE, 0); end
        else f_len++;
      end else if (f_prev) report(EV_FFALL, f_len);
      x_prev = explode;
      f_prev = flame_active;
    end
  end

  // Bounded wait for explode (which=0) or flame_active (which=1) to reach lvl.
  task automatic wait_for(input int which, input logic lvl, input int max, input string name);
    bit got = 0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge frame_clk);
      if ((which == 0 ? explode : flame_active) == lvl) got = 1;
    end
    #1;
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL %s: timed out after %0d cycles, expected level %0d", name, max, lvl);
    end
  endtask

  task automatic arm(input int x, input int y);
    @(negedge frame_clk);
    bombX = 10'(x);
    bombY = 10'(y);
    bomb_check = 1'b1;
    arm_cyc = cyc + 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_explode"}, int'(explode), 0);
    check({tag, "_fuse_warn"}, int'(fuse_warn), 0);
    check({tag, "_flame_active"}, int'(flame_active), 0);
    check({tag, "_edges_or"}, int'(flameXL | flameXR | flameYT | flameYB), 0);
  endtask

  initial begin
    int toggles;
    int ev0;
    logic warn_prev;
    bit got;

    #2 check_all_zero("reset");
    repeat (3) @(negedge frame_clk);
    Reset = 1'b1;
    repeat (2) @(negedge frame_clk);

    // Timed fuse at (100,200), bomb retired right after explode.
    push(EV_XRISE, 121, 0, 0, 0, 0);
    push(EV_FRISE, 0, 68, 132, 168, 232);
    push(EV_XFALL, 2, 0, 0, 0, 0);
    push(EV_FFALL, 30, 0, 0, 0, 0);
    arm(100, 200);
    toggles = 0; warn_prev = 1'b0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge frame_clk);
      if (fuse_warn != warn_prev) toggles++;
      warn_prev = fuse_warn;
      if (explode) got = 1;
    end
    check("explode_seen", int'(got), 1);
    check("fuse_warn_toggles", toggles, 8);
    bomb_check = 1'b0;
    wait_for(1, 1'b1, 10, "flame_rise_t1");
    wait_for(1, 1'b0, 40, "flame_fall_t1");
    check("t1_sb_drained", sb.size(), 0);
    check("edges_hold_xl", int'(flameXL), 68);
    repeat (3) @(negedge frame_clk);
    check("t1_idle_explode", int'(explode), 0);

    // Clamped corner bomb, bomb_check held through BLAST: timeout-limited explode.
    push(EV_XRISE, 121, 0, 0, 0, 0);
    push(EV_FRISE, 0, 0, 42, 438, 479);
    push(EV_XFALL, 4, 0, 0, 0, 0);
    push(EV_FFALL, 30, 0, 0, 0, 0);
    arm(10, 470);
    wait_for(0, 1'b1, 200, "explode_rise_t2");
    wait_for(0, 1'b0, 10, "explode_fall_t2");
    bomb_check = 1'b0;
    wait_for(1, 1'b0, 40, "flame_fall_t2");
    check("t2_sb_drained", sb.size(), 0);
    repeat (3) @(negedge frame_clk);

    // Retired at fuse count 50: no events at all.
    arm(300, 300);
    repeat (70) @(negedge frame_clk);
    bomb_check = 1'b0;
    ev0 = ev_count;
    repeat (150) @(negedge frame_clk);
    #1;
    check("t3_no_events", ev_count, ev0);
    check("t3_explode", int'(explode), 0);
    check("t3_flame_active", int'(flame_active), 0);

    // Reset in the middle of FLAME, then re-arm from the still-present bomb.
    push(EV_XRISE, 121, 0, 0, 0, 0);
    push(EV_FRISE, 0, 288, 352, 208, 272);
    push(EV_XFALL, 4, 0, 0, 0, 0);
    arm(320, 240);
    wait_for(1, 1'b1, 200, "flame_rise_t4");
    repeat (3) @(negedge frame_clk);
    check("t4_pre_reset_flame", int'(flame_active), 1);
    #3 Reset = 1'b0;
    #1 check_all_zero("midflame_reset");
    repeat (2) @(negedge frame_clk);
    check("t4_sb_drained", sb.size(), 0);
    push(EV_XRISE, 121, 0, 0, 0, 0);
    push(EV_FRISE, 0, 288, 352, 208, 272);
    push(EV_XFALL, 2, 0, 0, 0, 0);
    push(EV_FFALL, 30, 0, 0, 0, 0);
    Reset = 1'b1;
    arm_cyc = cyc + 1;
    wait_for(0, 1'b1, 200, "explode_rise_t5");
    bomb_check = 1'b0;
    wait_for(1, 1'b1, 10, "flame_rise_t5");
    wait_for(1, 1'b0, 40, "flame_fall_t5");
    check("t5_sb_drained", sb.size(), 0);

`ifdef CHAIN_TRIGGER_EN
    // Chain hit sampled while the fuse counter reads 80.
    push(EV_XRISE, 41, 0, 0, 0, 0);
    push(EV_FRISE, 0, 68, 132, 168, 232);
    push(EV_XFALL, 2, 0, 0, 0, 0);
    push(EV_FFALL, 30, 0, 0, 0, 0);
    arm(100, 200);
    repeat (40) @(negedge frame_clk);
    chain_hit = 1'b1;
    @(negedge frame_clk);
    chain_hit = 1'b0;
    wait_for(0, 1'b1, 10, "explode_rise_chain");
    bomb_check = 1'b0;
    wait_for(1, 1'b0, 50, "flame_fall_chain");
    check("chain_sb_drained", sb.size(), 0);
`endif

    repeat (3) @(negedge frame_clk);
    #1 check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
